dice_roll_sequencer: RTL

DICE_ROLL_SEQUENCER -- requirements
Module: dice_roll_sequencer

---
 rtl/dice_roll_sequencer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/dice_roll_sequencer.sv
// Multi-die roll sequencer: issues one roll per die, accumulates total and max, aborts on timeout.
// Optional macro DICE_SEQ_RANGE_CHECK_EN rejects results outside 1..faces of the selected die.
module dice_roll_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [3:0]  num_dice,
    input  logic [1:0]  die_type,
    output logic [1:0]  die_select,
    output logic        roll,
    input  logic [7:0]  rolled_number,
    input  logic        rolled_valid,
    output logic        busy,
    output logic        done,
    output logic [11:0] total,
    output logic [7:0]  max_roll,
    output logic        error
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned SEL_W = 2;
    localparam int unsigned TMR_W = 8;
    localparam int unsigned TOT_W = 12;
    localparam int unsigned RES_W = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   num_q, num_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [TOT_W-1:0]   total_q, total_d;
    logic [RES_W-1:0]   max_q, max_d;
    logic               error_q, error_d;
    logic               roll_q, roll_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               result_ok_c;

`ifdef DICE_SEQ_RANGE_CHECK_EN
    logic [RES_W-1:0]   faces_c;

    always_comb begin
        case (sel_q)
            2'd0:    faces_c = RES_W'(4);
            2'd1:    faces_c = RES_W'(6);
            2'd2:    faces_c = RES_W'(8);
            default: faces_c = RES_W'(20);
        endcase
        result_ok_c = (rolled_number != '0) && (rolled_number <= faces_c);
    end
`else
    assign result_ok_c = 1'b1;
`endif

    // Next-state and datapath; registered outputs track the next state so they align with it.
    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        cnt_d   = cnt_q;
        tmr_d   = tmr_q;
        sel_d   = sel_q;
        total_d = total_q;
        max_d   = max_q;
        error_d = error_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    num_d   = num_dice;
                    sel_d   = die_type;
                    total_d = '0;
                    max_d   = '0;
                    error_d = 1'b0;
                    cnt_d   = '0;
                    tmr_d   = '0;
                    state_d = (num_dice == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                tmr_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (rolled_valid) begin
                    if (result_ok_c) begin
                        total_d = total_q + TOT_W'(rolled_number);
                        if (rolled_number > max_q) begin
                            max_d = rolled_number;
                        end
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = (cnt_d == num_q) ? S_DONE : S_ISSUE;
                    end else begin
                        error_d = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                    if (32'(tmr_q) + 32'd1 >= 32'(TIMEOUT_CYCLES)) begin
                        error_d = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        roll_d = (state_d == S_ISSUE);
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            num_q   <= '0;
            cnt_q   <= '0;
            tmr_q   <= '0;
            sel_q   <= '0;
            total_q <= '0;
            max_q   <= '0;
            error_q <= 1'b0;
            roll_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
            sel_q   <= sel_d;
            total_q <= total_d;
            max_q   <= max_d;
            error_q <= error_d;
            roll_q  <= roll_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign die_select = sel_q;
    assign roll       = roll_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign total      = total_q;
    assign max_roll   = max_q;
    assign error      = error_q;

endmodule
